// File: rtl/sram_pkg.sv
// Shared types and default geometry for the banked SRAM chain and its channel requesters.
package sram_pkg;

  localparam int unsigned SRAM_MEM_NUM    = 16;
  localparam int unsigned SRAM_MEM_WIDTH  = 32;
  localparam int unsigned SRAM_MEM_DEPTH  = 2048;
  localparam int unsigned SRAM_RD_LAT     = 2;
  localparam int unsigned SRAM_RSP_DEPTH  = 4;
  localparam int unsigned SRAM_ADDR_WIDTH = $clog2(SRAM_MEM_DEPTH);
  localparam int unsigned SRAM_BANK_WIDTH = $clog2(SRAM_MEM_NUM);

  typedef struct packed {
    logic                       wr;
    logic [SRAM_BANK_WIDTH-1:0] bank;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_MEM_WIDTH-1:0]  data;
  } mem_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Response FIFO for read data; head entry is presented combinationally, no push-to-pop bypass.
module sram_rsp_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             pop_eff;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_eff   = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/sram_chan_requester.sv
// Channel-side initiator: issues one request per cycle into the bank chain and returns
// read data in order through a credit-protected response FIFO.
module sram_chan_requester
  import sram_pkg::*;
#(
  parameter int unsigned MEM_NUM    = SRAM_MEM_NUM,
  parameter int unsigned MEM_WIDTH  = SRAM_MEM_WIDTH,
  parameter int unsigned MEM_DEPTH  = SRAM_MEM_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int unsigned BANK_WIDTH = $clog2(MEM_NUM),
  parameter int unsigned RD_LAT     = SRAM_RD_LAT,
  parameter int unsigned RSP_DEPTH  = SRAM_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [BANK_WIDTH-1:0] req_bank,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MEM_WIDTH-1:0]  req_data,
  output logic [MEM_NUM-1:0]    mem_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [MEM_WIDTH-1:0]  wr_data,
  input  logic [MEM_WIDTH-1:0]  rd_data_ret,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [MEM_WIDTH-1:0]  rsp_data
);

  localparam int unsigned CW    = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SEL_W = 1 << BANK_WIDTH;

  logic [CW-1:0]         credit_q, credit_d;
  logic [MEM_NUM-1:0]    mem_en_q, mem_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                  rd_iss_q, rd_iss_d;
  logic [RD_LAT-1:0]     lat_q;
  logic [SEL_W-1:0]      bank_dec;
  logic                  acc, rd_acc, pop, push;
  logic                  fifo_empty, fifo_full;

  assign req_rdy = (credit_q != '0);
  assign acc     = req_vld & req_rdy;
  assign rd_acc  = acc & ~req_wr;
  assign pop     = rsp_vld & rsp_rdy;
  assign push    = lat_q[RD_LAT-1];

  // Credits cover reads in flight plus entries held in the FIFO.
  always_comb begin
    credit_d = credit_q;
    case ({rd_acc, pop})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  // Decoding into a power-of-2 vector drops out-of-range banks when truncated to MEM_NUM.
  always_comb begin
    bank_dec           = '0;
    bank_dec[req_bank] = 1'b1;
    mem_en_d           = '0;
    wr_en_d            = 1'b0;
    addr_d             = addr_q;
    wr_data_d          = wr_data_q;
    rd_iss_d           = 1'b0;
    if (acc) begin
      mem_en_d  = bank_dec[MEM_NUM-1:0];
      wr_en_d   = req_wr;
      addr_d    = req_addr;
      wr_data_d = req_wr ? req_data : '0;
      rd_iss_d  = ~req_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q  <= CW'(RSP_DEPTH);
      mem_en_q  <= '0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_iss_q  <= 1'b0;
      lat_q     <= '0;
    end else begin
      credit_q  <= credit_d;
      mem_en_q  <= mem_en_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_iss_q  <= rd_iss_d;
      lat_q[0]  <= rd_iss_q;
      for (int i = 1; i < RD_LAT; i++) lat_q[i] <= lat_q[i-1];
    end
  end

  assign mem_en  = mem_en_q;
  assign wr_en   = wr_en_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;

  sram_rsp_fifo #(
    .WIDTH (MEM_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rd_data_ret),
    .pop       (pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head_data (rsp_data)
  );

  assign rsp_vld = ~fifo_empty;

  a_full_no_credit: assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> (credit_q == '0));

endmodule

// File: doc/sram_chan_requester.md
# sram_chan_requester

Channel-side initiator for the banked SRAM chain. It accepts read and write requests from one vector-cache channel over a valid/ready interface and drives that channel's enable, write, address and data lanes into the chain of SRAM bank instances. It recovers read data from the AND-combined return lane after a fixed bank latency and delivers responses in order through a credit-protected response FIFO.

## Interface
- MEM_NUM, 16, number of banks on the chain
- MEM_WIDTH, 32, data width per bank
- MEM_DEPTH, 2048, words per bank
- ADDR_WIDTH, $clog2(MEM_DEPTH), word address width
- BANK_WIDTH, $clog2(MEM_NUM), bank index width
- RD_LAT, 2, cycles from bank enable to valid data on the return lane (≥1)
- RSP_DEPTH, 4, response FIFO entries and read credits (power of 2, ≥2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_wr  in  1  1 = write, 0 = read
- req_bank  in  BANK_WIDTH  target bank
- req_addr  in  ADDR_WIDTH  word address
- req_data  in  MEM_WIDTH  write data
- mem_en  out  MEM_NUM  one-hot bank enable into the chain
- wr_en  out  1  write strobe, qualified by mem_en
- addr  out  ADDR_WIDTH  address lane
- wr_data  out  MEM_WIDTH  write data lane
- rd_data_ret  in  MEM_WIDTH  AND-combined read return from the chain tail; all-ones when no bank drives it
- rsp_vld  out  1  read response valid
- rsp_rdy  in  1  read response ready
- rsp_data  out  MEM_WIDTH  read response data

## Operation
- Accept: the request is accepted when req_vld and req_rdy are both high.
- req_rdy = (credit_cnt != 0). It does not depend on req_wr or req_vld.
- credit_cnt range is 0..RSP_DEPTH. A read acceptance decrements it, a response handshake increments it, and both in one cycle leave it unchanged. Writes never consume credit.
- Issue stage: on acceptance, registered outputs load on the next edge.
  - mem_en = one-hot(req_bank), wr_en = req_wr, addr = req_addr.
  - wr_data = req_data for writes, 0 for reads.
- With no acceptance, mem_en and wr_en return to 0 and addr/wr_data hold their values.
- req_bank ≥ MEM_NUM (possible only for non-power-of-2 MEM_NUM): the request is accepted and mem_en stays 0. A read of this kind still consumes a credit and returns all-ones.
- Read tracking: a 1-bit valid shift register of RD_LAT stages is fed by (issue-stage mem_en-or-bad-bank read). When the last stage is set, rd_data_ret is written into the FIFO.
- Response FIFO: `rsp_vld` = not empty, rsp_data = head entry. It pops on rsp_vld & rsp_rdy. Pointers wrap modulo RSP_DEPTH. The credit scheme guarantees no overflow; a write while full is an assertion failure.
- Ordering: responses are strictly in read-acceptance order. Writes produce no response.

## Timing
- Read accepted at cycle T:
  - mem_en is high during T+1.
  - rd_data_ret is sampled at the end of T+1+RD_LAT.
  - rsp_vld is high from T+2+RD_LAT. With the defaults this is T+4.
- Write accepted at T: mem_en and wr_en are high during T+1 only.
- Back-to-back requests are issued one per cycle with no bubbles while credit remains.
- Pop and push in the same cycle on a full or empty FIFO are both legal. On an empty FIFO, the pushed data appears at T+1 and does not bypass.
- Reset values:
  - mem_en = 0, wr_en = 0, addr = 0, wr_data = 0.
  - rsp_vld = 0, rsp_data = 0.
  - credit_cnt = RSP_DEPTH, so req_rdy = 1 once rst_n is released.
- Reset mid-operation: in-flight read tags and FIFO contents are discarded, credits are restored, and no stale response appears after reset.

## Structure
- Shared package sram_pkg:
  - mem_req_t struct (wr, bank, addr, data).
  - Default constants for MEM_NUM, MEM_WIDTH, MEM_DEPTH, RD_LAT.
- Sub-module sram_rsp_fifo (parameters: WIDTH, DEPTH): synchronous FIFO with push, pop, empty, full and head data outputs, async active-low reset.
- Top level contains the credit counter, issue registers and latency shift register.

## Test plan
- Single read: bank 3, addr 0x10, rd_data_ret = 0xDEADBEEF at T+3 → mem_en = 0x0008 at T+1, rsp_vld with 0xDEADBEEF at T+4.
- Write then read: write 0xA5A5A5A5 to bank 0, addr 5 → mem_en = 0x0001, wr_en = 1, wr_data = 0xA5A5A5A5 at T+1, no response. The following read returns the modelled bank value.
- Credit exhaustion: 4 reads with rsp_rdy = 0 → req_rdy drops after the 4th acceptance. One rsp_rdy pulse → req_rdy = 1 on the next cycle, and FIFO order is preserved.
- Simultaneous: with credit_cnt = 1, a read is accepted in the same cycle as a response pop → credit stays 1 and req_rdy stays high.
- Stream: 16 back-to-back reads with rsp_rdy = 1 → 16 consecutive responses in order, no stalls after the first response.
- Reset during in-flight reads: assert rst_n low at T+2 of two reads → all outputs return to their reset values, rsp_vld never rises, req_rdy = 1 after release.
